// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encodings, default opcodes, DR-select type.
// Latency: n/a (types and pure functions only); no backpressure.
package jtag_pkg;

    localparam int TAP_STATE_W = 4;

    // Standard 1149.1 encodings so TapState matches common debug tooling.
    typedef enum logic [TAP_STATE_W-1:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tapState_t;

    localparam logic [3:0] DEF_OPC_EXTEST         = 4'b0000;
    localparam logic [3:0] DEF_OPC_SAMPLE_PRELOAD = 4'b0001;
    localparam logic [3:0] DEF_OPC_IDCODE         = 4'b0010;
    localparam logic [3:0] DEF_OPC_BYPASS         = 4'b1111;

    typedef enum logic [1:0] {
        DRSEL_BYPASS = 2'd0,
        DRSEL_IDCODE = 2'd1,
        DRSEL_BSR    = 2'd2
    } drSel_t;

    function automatic tapState_t nextTapState(input tapState_t cur, input logic tms);
        case (cur)
            TEST_LOGIC_RESET: nextTapState = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    nextTapState = tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        nextTapState = tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       nextTapState = tms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:         nextTapState = tms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:         nextTapState = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         nextTapState = tms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:         nextTapState = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        nextTapState = tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_IR:        nextTapState = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       nextTapState = tms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:         nextTapState = tms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:         nextTapState = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         nextTapState = tms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:         nextTapState = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        nextTapState = tms ? SELECT_DR : RUN_TEST_IDLE;
            default:          nextTapState = TEST_LOGIC_RESET;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine: TMS graph on rising TCK, sync reset to TEST_LOGIC_RESET.
// Latency: state updates one TCK after TMS is sampled; no backpressure.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic      TCK,
    input  logic      RST,
    input  logic      TMS,
    output tapState_t tapState
);

    always_ff @(posedge TCK) begin
        if (RST) begin
            tapState <= TEST_LOGIC_RESET;
        end else begin
            tapState <= nextTapState(tapState, TMS);
        end
    end

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller: FSM, instruction register, BYPASS/IDCODE DRs, boundary strobes, TDO mux.
// Latency: registers act on rising TCK, TDO/TDO_en launch on falling TCK; no backpressure.
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int                     IR_WIDTH           = 4,
    parameter logic [31:0]            IDCODE_VAL         = 32'h0000_0001,
    parameter logic [IR_WIDTH-1:0]    OPC_EXTEST         = IR_WIDTH'(DEF_OPC_EXTEST),
    parameter logic [IR_WIDTH-1:0]    OPC_SAMPLE_PRELOAD = IR_WIDTH'(DEF_OPC_SAMPLE_PRELOAD),
    parameter logic [IR_WIDTH-1:0]    OPC_IDCODE         = IR_WIDTH'(DEF_OPC_IDCODE),
    parameter logic [IR_WIDTH-1:0]    OPC_BYPASS         = IR_WIDTH'(DEF_OPC_BYPASS)
) (
    input  logic       TCK,
    input  logic       RST,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       BSChainTDO,
    output logic       TDO,
    output logic       TDO_en,
    output logic       CaptureDR,
    output logic       ShiftDR,
    output logic       UpdateDR,
    output logic       sample_preload,
    output logic       TestLogicReset,
    output logic [3:0] TapState
);

    tapState_t             state;
    logic [IR_WIDTH-1:0]   irShift;
    logic [IR_WIDTH-1:0]   activeInstr;
    logic                  bypassReg;
    logic [31:0]           idcodeReg;
    drSel_t                drSel;
    logic                  tdoMux;
    logic                  tdoEnMux;
    logic                  tdoReg;
    logic                  tdoEnReg;

    jtag_tap_fsm uFsm (
        .TCK      (TCK),
        .RST      (RST),
        .TMS      (TMS),
        .tapState (state)
    );

    // BYPASS is explicit here only for readability; any unknown opcode lands on it too.
    always_comb begin
        drSel = DRSEL_BYPASS;
        if (activeInstr == OPC_EXTEST || activeInstr == OPC_SAMPLE_PRELOAD) begin
            drSel = DRSEL_BSR;
        end else if (activeInstr == OPC_IDCODE) begin
            drSel = DRSEL_IDCODE;
        end else if (activeInstr == OPC_BYPASS) begin
            drSel = DRSEL_BYPASS;
        end
    end

    always_ff @(posedge TCK) begin
        if (RST) begin
            irShift     <= '0;
            activeInstr <= OPC_IDCODE;
            bypassReg   <= 1'b0;
            idcodeReg   <= '0;
        end else begin
            case (state)
                TEST_LOGIC_RESET: activeInstr <= OPC_IDCODE;
                CAPTURE_IR:       irShift     <= IR_WIDTH'(2'b01);
                SHIFT_IR:         irShift     <= {TDI, irShift[IR_WIDTH-1:1]};
                UPDATE_IR:        activeInstr <= irShift;
                CAPTURE_DR: begin
                    if (drSel == DRSEL_BYPASS) begin
                        bypassReg <= 1'b0;
                    end else if (drSel == DRSEL_IDCODE) begin
                        idcodeReg <= IDCODE_VAL;
                    end
                end
                SHIFT_DR: begin
                    if (drSel == DRSEL_BYPASS) begin
                        bypassReg <= TDI;
                    end else if (drSel == DRSEL_IDCODE) begin
                        idcodeReg <= {TDI, idcodeReg[31:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tdoMux   = 1'b0;
        tdoEnMux = 1'b0;
        case (state)
            SHIFT_IR: begin
                tdoMux   = irShift[0];
                tdoEnMux = 1'b1;
            end
            SHIFT_DR: begin
                tdoEnMux = 1'b1;
                case (drSel)
                    DRSEL_IDCODE: tdoMux = idcodeReg[0];
                    DRSEL_BSR:    tdoMux = BSChainTDO;
                    default:      tdoMux = bypassReg;
                endcase
            end
            default: ;
        endcase
    end

    // Falling-edge launch gives the far end half a TCK of setup before it samples.
    always_ff @(negedge TCK) begin
        tdoReg   <= tdoMux;
        tdoEnReg <= tdoEnMux;
    end

    assign TDO            = tdoReg;
    assign TDO_en         = tdoEnReg;
    assign CaptureDR      = (state == CAPTURE_DR) && (drSel == DRSEL_BSR);
    assign ShiftDR        = (state == SHIFT_DR)   && (drSel == DRSEL_BSR);
    assign UpdateDR       = (state == UPDATE_DR)  && (drSel == DRSEL_BSR);
    assign sample_preload = (activeInstr == OPC_EXTEST);
    assign TestLogicReset = (state == TEST_LOGIC_RESET);
    assign TapState       = state;

endmodule

// File: doc/jtag_tap_controller.md
Name: jtag_tap_controller

Overview:
- IEEE 1149.1-style TAP controller that sequences the boundary-scan chain built from jtag_InputCell instances.
- Contains the 16-state TAP FSM, instruction register, BYPASS and IDCODE data registers, and the TDO output mux.
- Drives the CaptureDR, ShiftDR, UpdateDR and sample_preload strobes consumed by every boundary cell.
- Sits between the chip JTAG pins and the boundary chain.

Parameters:
- IR_WIDTH, 4, instruction register length in bits.
- IDCODE_VAL, 32'h0000_0001, value captured into the IDCODE register; bit 0 must be 1.
- OPC_EXTEST, 4'b0000, EXTEST opcode.
- OPC_SAMPLE_PRELOAD, 4'b0001, SAMPLE/PRELOAD opcode.
- OPC_IDCODE, 4'b0010, IDCODE opcode.
- OPC_BYPASS, 4'b1111, BYPASS opcode.

Ports:
- TCK  input  1  test clock; the only clock.
- RST  input  1  synchronous, active-high reset, sampled on rising TCK.
- TMS  input  1  test mode select, sampled on rising TCK.
- TDI  input  1  serial data in; fanned out to IR, BYPASS, IDCODE and the first boundary cell.
- BSChainTDO  input  1  ToNextBSCell output of the last boundary cell.
- TDO  output  1  serial data out, registered on falling TCK.
- TDO_en  output  1  high only while in SHIFT_IR or SHIFT_DR (registered with TDO).
- CaptureDR  output  1  boundary capture strobe: state==CAPTURE_DR and boundary register selected.
- ShiftDR  output  1  boundary shift strobe: state==SHIFT_DR and boundary register selected.
- UpdateDR  output  1  boundary update strobe: state==UPDATE_DR and boundary register selected.
- sample_preload  output  1  core-drive select to the cells; high while the active instruction is EXTEST.
- TestLogicReset  output  1  high in TEST_LOGIC_RESET.
- TapState  output  4  current FSM state encoding, for debug.

Behaviour:
- FSM has the standard 16 states: TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, and the matching *_IR states.
- Transitions follow the standard TMS graph on rising TCK.
- Five consecutive TMS=1 cycles reach TEST_LOGIC_RESET from any state.
- RST=1 on a rising edge forces, on that edge:
  - state=TEST_LOGIC_RESET
  - IR shift register=0
  - active instruction=OPC_IDCODE
  - BYPASS=0, IDCODE shift register=0
- After reset, outputs are: TDO=0 and TDO_en=0 (at the next falling edge); strobes low; sample_preload=0; TestLogicReset=1.
- RST asserted mid-shift aborts the shift; no update occurs.
- Entering TEST_LOGIC_RESET via TMS has the same effect on the active instruction (IDCODE) as RST.
- Strobes (CaptureDR, ShiftDR, UpdateDR, TestLogicReset) are decoded combinationally from the registered state, so they are glitch-free relative to rising TCK.
  - Cells capture/shift on rising TCK while the state is held.
  - Cells update on falling TCK during UPDATE_DR.
- Boundary register is selected when the active instruction is EXTEST or SAMPLE_PRELOAD.
  - IDCODE selects the 32-bit IDCODE register.
  - BYPASS and every undefined opcode select the 1-bit BYPASS register.
- CAPTURE_IR loads IR shift register = {IR_WIDTH-2 zeros, 2'b01}.
- SHIFT_IR shifts right, TDI entering the MSB, LSB presented on TDO.
- UPDATE_IR copies the shift register into the active instruction on rising TCK while in UPDATE_IR. The new instruction is therefore effective from the next state.
- CAPTURE_DR behaviour by selected register:
  - BYPASS loads 0.
  - IDCODE loads IDCODE_VAL.
  - Boundary: the controller only raises CaptureDR.
- SHIFT_DR shifts the selected internal register right with TDI in; boundary data comes from BSChainTDO.
- PAUSE_* and EXIT*_* states hold all registers.
- TDO is captured on falling TCK from the mux:
  - SHIFT_IR: IR LSB.
  - SHIFT_DR: selected DR LSB, or BSChainTDO for the boundary register.
  - Otherwise TDO=0 and TDO_en=0.
- sample_preload changes only on active-instruction update or reset; it is never pulsed by the FSM.

Decomposition:
- Package jtag_pkg holds:
  - the state localparams (4-bit encodings, TEST_LOGIC_RESET=4'hF);
  - default opcodes;
  - the DR-select enum (DRSEL_BYPASS, DRSEL_IDCODE, DRSEL_BSR).
- One sub-module is natural: jtag_tap_fsm (TCK, RST, TMS -> state). It is pure next-state plus state register, reusable by other JTAG blocks.
- Instruction decode, data registers and TDO mux stay in the top.

Test Plan:
- Reset: RST=1 for 1 cycle, then TMS=0 -> TapState=RUN_TEST_IDLE.
  - Shift 32 bits of DR with TDI=0 -> TDO stream equals 32'h0000_0001 LSB first.
  - TDO_en=1 only during the 32 SHIFT_DR cycles.
- TMS recovery: from SHIFT_DR, apply TMS=1 five times -> TestLogicReset=1.
  - Active instruction returns to IDCODE, with no UpdateDR pulse on the path through UPDATE_DR. UpdateDR stays low because IDCODE is active.
- IR capture/shift: load IR with 4'b1111 -> first 4 TDO bits during SHIFT_IR are 1,0,0,0.
  - Subsequent DR shift with TDI pattern 1,0,1 -> TDO delayed by exactly one bit: 0,1,0,1.
  - Undefined opcode 4'b0101 behaves identically to BYPASS.
- Boundary sequencing: load EXTEST, run CAPTURE_DR→SHIFT_DR x8→UPDATE_DR with an 8-cell chain model.
  - CaptureDR high for 1 cycle, ShiftDR high for 8 cycles, UpdateDR high for 1 cycle.
  - sample_preload=1 from the cycle after UPDATE_IR.
  - TDO reproduces BSChainTDO.
- Pause: SHIFT_DR→EXIT1_DR→PAUSE_DR x3→EXIT2_DR→SHIFT_DR mid-IDCODE.
  - Remaining bits continue without loss or duplication.
  - ShiftDR is low during the pause.
- Reset mid-shift: assert RST during SHIFT_IR after 2 bits -> active instruction=IDCODE, IR shift register=0, no UPDATE_IR effect.
